// File: rtl/elbeth_fetch_stage_if.sv
// ELBETH fetch-stage bus bundle: instruction-memory handshake, redirect
// from execute, decode stall and the IF/ID register outputs.
interface elbeth_fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic        id_stall;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [6:0]  opcode;
   logic [4:0]  inst_0;
   logic [2:0]  inst_1;
   logic [4:0]  inst_2;
   logic [4:0]  inst_3;
   logic [6:0]  inst_4;

   // Fetch stage side
   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_data,
      input  ex_branch_taken, ex_branch_target,
      input  id_stall,
      output if_valid, if_pc, opcode, inst_0, inst_1, inst_2, inst_3, inst_4
   );

   // Memory / execute / decode side
   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_data,
      output ex_branch_taken, ex_branch_target,
      output id_stall,
      input  if_valid, if_pc, opcode, inst_0, inst_1, inst_2, inst_3, inst_4
   );
endinterface

// File: rtl/elbeth_fetch_stage.sv
// ELBETH RV32I instruction fetch stage with IF/ID register.
// Holds the PC, issues word fetches over req/ack, buffers one word in a
// skid entry while decode stalls, and redirects on taken branches.
module elbeth_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic                   clk,
   input logic                   rst,
   elbeth_fetch_stage_if.master  bus
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   // r_run is low for the reset cycle so the request line reads 0 while
   // reset is being applied, then goes high for good.
   logic        r_run;
   logic [31:0] r_pc;
   logic [31:0] r_drain_addr;
   logic        r_if_valid;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_inst;
   logic        r_skid_valid;
   logic [31:0] r_skid_pc;
   logic [31:0] r_skid_inst;

   logic [31:0] w_pc_next;
   logic [31:0] w_drain_addr_next;
   logic        w_if_valid_next;
   logic [31:0] w_if_pc_next;
   logic [31:0] w_if_inst_next;
   logic        w_skid_valid_next;
   logic [31:0] w_skid_pc_next;
   logic [31:0] w_skid_inst_next;

   logic        w_req;
   logic        w_ack;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;

   // Request/address depend only on registered state; DRAIN keeps the
   // address of the abandoned request stable until memory acks it.
   assign w_req          = r_run && (r_state != ST_HOLD);
   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;

   // An ack only counts while a request is actually being presented.
   assign w_ack      = bus.imem_ack && w_req;
   assign w_target   = bus.ex_branch_target & ~32'h0000_0003;
   assign w_pc_plus4 = r_pc + 32'd4;

   assign bus.if_valid = r_if_valid;
   assign bus.if_pc    = r_if_pc;
   assign bus.opcode   = r_if_inst[6:0];
   assign bus.inst_0   = r_if_inst[11:7];
   assign bus.inst_1   = r_if_inst[14:12];
   assign bus.inst_2   = r_if_inst[19:15];
   assign bus.inst_3   = r_if_inst[24:20];
   assign bus.inst_4   = r_if_inst[31:25];

   // Next-state and datapath update: redirect beats stall beats ack.
   always_comb begin
      w_state_next      = r_state;
      w_pc_next         = r_pc;
      w_drain_addr_next = r_drain_addr;
      w_if_valid_next   = r_if_valid;
      w_if_pc_next      = r_if_pc;
      w_if_inst_next    = r_if_inst;
      w_skid_valid_next = r_skid_valid;
      w_skid_pc_next    = r_skid_pc;
      w_skid_inst_next  = r_skid_inst;

      if (bus.ex_branch_taken) begin
         w_pc_next         = w_target;
         w_if_valid_next   = 1'b0;
         w_if_inst_next    = NOP_INST;
         w_skid_valid_next = 1'b0;
         if ((r_state == ST_FETCH) && w_req && !w_ack) begin
            // Outstanding request must still complete; its data is dropped.
            w_state_next      = ST_DRAIN;
            w_drain_addr_next = r_pc;
         end else if ((r_state == ST_DRAIN) && !w_ack) begin
            // Old request is still pending: keep draining it.
            w_state_next = ST_DRAIN;
         end else begin
            w_state_next = ST_FETCH;
         end
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (bus.id_stall) begin
                  if (w_ack) begin
                     w_skid_valid_next = 1'b1;
                     w_skid_pc_next    = r_pc;
                     w_skid_inst_next  = bus.imem_data;
                     w_pc_next         = w_pc_plus4;
                     w_state_next      = ST_HOLD;
                  end
               end else if (w_ack) begin
                  w_if_valid_next = 1'b1;
                  w_if_pc_next    = r_pc;
                  w_if_inst_next  = bus.imem_data;
                  w_pc_next       = w_pc_plus4;
               end else begin
                  w_if_valid_next = 1'b0;
                  w_if_inst_next  = NOP_INST;
               end
            end
            ST_HOLD: begin
               if (!bus.id_stall) begin
                  w_if_valid_next   = r_skid_valid;
                  w_if_pc_next      = r_skid_pc;
                  w_if_inst_next    = r_skid_inst;
                  w_skid_valid_next = 1'b0;
                  w_state_next      = ST_FETCH;
               end
            end
            ST_DRAIN: begin
               if (!bus.id_stall) begin
                  w_if_valid_next = 1'b0;
                  w_if_inst_next  = NOP_INST;
               end
               if (w_ack) begin
                  w_state_next = ST_FETCH;
               end
            end
            default: begin
               w_state_next = ST_FETCH;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // PC, IF/ID register, skid entry and drain address.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_run        <= 1'b0;
         r_pc         <= RESET_PC;
         r_drain_addr <= RESET_PC;
         r_if_valid   <= 1'b0;
         r_if_pc      <= 32'd0;
         r_if_inst    <= NOP_INST;
         r_skid_valid <= 1'b0;
         r_skid_pc    <= 32'd0;
         r_skid_inst  <= NOP_INST;
      end else begin
         r_run        <= 1'b1;
         r_pc         <= w_pc_next;
         r_drain_addr <= w_drain_addr_next;
         r_if_valid   <= w_if_valid_next;
         r_if_pc      <= w_if_pc_next;
         r_if_inst    <= w_if_inst_next;
         r_skid_valid <= w_skid_valid_next;
         r_skid_pc    <= w_skid_pc_next;
         r_skid_inst  <= w_skid_inst_next;
      end
   end

endmodule

// File: tb/tb_elbeth_fetch_stage.sv
// Directed bench for elbeth_fetch_stage: sequential fetch, field split,
// stall/skid, redirect with drain, redirect+stall, PC wrap and reset.
module tb_elbeth_fetch_stage;

   logic clk;
   logic rst;
   logic rst2;

   int   n_checks;
   int   n_fail;
   int   cyc;

   // Memory model controls for the main instance
   int          lat;
   int          wait_cnt;
   logic        ovr_en;
   logic [31:0] ovr_data;

   elbeth_fetch_stage_if bus();
   elbeth_fetch_stage_if bus2();

   elbeth_fetch_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   elbeth_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
      .clk (clk),
      .rst (rst2),
      .bus (bus2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: acks after lat cycles of a steady request; data is the address
   // unless an override word is selected.
   assign bus.imem_ack  = bus.imem_req && (wait_cnt >= lat - 1);
   assign bus.imem_data = ovr_en ? ovr_data : bus.imem_addr;

   always @(posedge clk) begin
      if (rst || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
      else                                      wait_cnt <= wait_cnt + 1;
   end

   // Second instance: zero-wait memory returning the address, no stalls.
   assign bus2.imem_ack         = bus2.imem_req;
   assign bus2.imem_data        = bus2.imem_addr;
   assign bus2.ex_branch_taken  = 1'b0;
   assign bus2.ex_branch_target = 32'd0;
   assign bus2.id_stall         = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d: req=%0b addr=%h if_valid=%0b if_pc=%h opcode=%h | hi: req=%0b addr=%h if_pc=%h",
               cyc, bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_pc, bus.opcode,
               bus2.imem_req, bus2.imem_addr, bus2.if_pc);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      rst2     = 1'b1;
      lat      = 1;
      ovr_en   = 1'b0;
      ovr_data = 32'd0;
      bus.id_stall         = 1'b0;
      bus.ex_branch_taken  = 1'b0;
      bus.ex_branch_target = 32'd0;

      tick();
      tick();
      check_eq("rst_req",    {31'd0, bus.imem_req}, 32'd0);
      check_eq("rst_addr",   bus.imem_addr, 32'd0);
      check_eq("rst_valid",  {31'd0, bus.if_valid}, 32'd0);
      check_eq("rst_if_pc",  bus.if_pc, 32'd0);
      check_eq("rst_opcode", {25'd0, bus.opcode}, 32'h13);
      check_eq("rst_inst4",  {25'd0, bus.inst_4}, 32'd0);

      // Sequential zero-wait fetch
      rst = 1'b0;
      tick();
      check_eq("seq0_req",   {31'd0, bus.imem_req}, 32'd1);
      check_eq("seq0_addr",  bus.imem_addr, 32'd0);
      check_eq("seq0_valid", {31'd0, bus.if_valid}, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_eq("seq_addr",   bus.imem_addr, 32'(4 * k));
         check_eq("seq_if_pc",  bus.if_pc, 32'(4 * (k - 1)));
         check_eq("seq_valid",  {31'd0, bus.if_valid}, 32'd1);
         check_eq("seq_opcode", {25'd0, bus.opcode}, 32'(4 * (k - 1)));
      end

      // Stall for three cycles while 0x10 is acked
      bus.id_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("stall_req",   {31'd0, bus.imem_req}, 32'd0);
         check_eq("stall_if_pc", bus.if_pc, 32'h0C);
         check_eq("stall_valid", {31'd0, bus.if_valid}, 32'd1);
      end
      bus.id_stall = 1'b0;
      tick();
      check_eq("rel_if_pc",  bus.if_pc, 32'h10);
      check_eq("rel_opcode", {25'd0, bus.opcode}, 32'h10);
      check_eq("rel_valid",  {31'd0, bus.if_valid}, 32'd1);
      check_eq("rel_req",    {31'd0, bus.imem_req}, 32'd1);
      check_eq("rel_addr",   bus.imem_addr, 32'h14);
      tick();
      check_eq("resume_if_pc", bus.if_pc, 32'h14);
      check_eq("resume_addr",  bus.imem_addr, 32'h18);

      // Field split
      ovr_en   = 1'b1;
      ovr_data = 32'hFE00_0EE3;
      tick();
      ovr_en = 1'b0;
      check_eq("fld_if_pc",  bus.if_pc, 32'h18);
      check_eq("fld_opcode", {25'd0, bus.opcode}, 32'h63);
      check_eq("fld_inst0",  {27'd0, bus.inst_0}, 32'h1D);
      check_eq("fld_inst1",  {29'd0, bus.inst_1}, 32'h0);
      check_eq("fld_inst2",  {27'd0, bus.inst_2}, 32'h0);
      check_eq("fld_inst3",  {27'd0, bus.inst_3}, 32'h0);
      check_eq("fld_inst4",  {25'd0, bus.inst_4}, 32'h7F);
      check_eq("fld_addr",   bus.imem_addr, 32'h1C);

      // Redirect to 0x40 with zero-wait memory
      bus.ex_branch_taken  = 1'b1;
      bus.ex_branch_target = 32'h40;
      tick();
      check_eq("br1_valid",  {31'd0, bus.if_valid}, 32'd0);
      check_eq("br1_opcode", {25'd0, bus.opcode}, 32'h13);
      check_eq("br1_addr",   bus.imem_addr, 32'h40);

      // Slow memory: redirect to 0x203 while 0x40 is pending
      lat = 3;
      bus.ex_branch_target = 32'h203;
      tick();
      bus.ex_branch_taken = 1'b0;
      check_eq("drn1_req",   {31'd0, bus.imem_req}, 32'd1);
      check_eq("drn1_addr",  bus.imem_addr, 32'h40);
      check_eq("drn1_valid", {31'd0, bus.if_valid}, 32'd0);
      tick();
      check_eq("drn2_addr",  bus.imem_addr, 32'h40);
      check_eq("drn2_valid", {31'd0, bus.if_valid}, 32'd0);
      tick();
      check_eq("drn3_addr",   bus.imem_addr, 32'h200);
      check_eq("drn3_valid",  {31'd0, bus.if_valid}, 32'd0);
      check_eq("drn3_opcode", {25'd0, bus.opcode}, 32'h13);
      tick();
      check_eq("wait_addr",  bus.imem_addr, 32'h200);
      check_eq("wait_valid", {31'd0, bus.if_valid}, 32'd0);
      lat = 1;
      tick();
      check_eq("tgt_valid", {31'd0, bus.if_valid}, 32'd1);
      check_eq("tgt_if_pc", bus.if_pc, 32'h200);
      check_eq("tgt_addr",  bus.imem_addr, 32'h204);

      // Redirect and stall in the same cycle
      bus.ex_branch_taken  = 1'b1;
      bus.ex_branch_target = 32'h300;
      bus.id_stall         = 1'b1;
      tick();
      bus.ex_branch_taken = 1'b0;
      bus.id_stall        = 1'b0;
      check_eq("brst_valid",  {31'd0, bus.if_valid}, 32'd0);
      check_eq("brst_opcode", {25'd0, bus.opcode}, 32'h13);
      check_eq("brst_addr",   bus.imem_addr, 32'h300);
      check_eq("brst_req",    {31'd0, bus.imem_req}, 32'd1);
      tick();
      check_eq("brst_if_pc",  bus.if_pc, 32'h300);
      check_eq("brst_valid2", {31'd0, bus.if_valid}, 32'd1);

      // PC wrap on the high-reset instance
      rst2 = 1'b0;
      tick();
      check_eq("wrap_a0", bus2.imem_addr, 32'hFFFF_FFF8);
      check_eq("wrap_req", {31'd0, bus2.imem_req}, 32'd1);
      tick();
      check_eq("wrap_a1", bus2.imem_addr, 32'hFFFF_FFFC);
      check_eq("wrap_pc1", bus2.if_pc, 32'hFFFF_FFF8);
      tick();
      check_eq("wrap_a2", bus2.imem_addr, 32'h0000_0000);
      check_eq("wrap_pc2", bus2.if_pc, 32'hFFFF_FFFC);
      tick();
      check_eq("wrap_a3", bus2.imem_addr, 32'h0000_0004);
      check_eq("wrap_pc3", bus2.if_pc, 32'h0000_0000);
      check_eq("wrap_valid", {31'd0, bus2.if_valid}, 32'd1);

      // Mid-stream reset
      rst2 = 1'b1;
      tick();
      check_eq("mrst_req",    {31'd0, bus2.imem_req}, 32'd0);
      check_eq("mrst_addr",   bus2.imem_addr, 32'hFFFF_FFF8);
      check_eq("mrst_valid",  {31'd0, bus2.if_valid}, 32'd0);
      check_eq("mrst_if_pc",  bus2.if_pc, 32'd0);
      check_eq("mrst_opcode", {25'd0, bus2.opcode}, 32'h13);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
